calc_cmd_scheduler: RTL and testbench

Command queue and issue sequencer between the debounced button actions and the calculator stack datapath. It buffers push, shift-and-push and other-op commands, together with their switch payloads, in a small FIFO. It issues them one at a time as single-cycle pulses, holding off while the calculator reports a multi-cycle operation in progress, so that button actions arriving during busy periods are not lost.

---
 rtl/calc_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_calc_cmd_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : calc_cmd_scheduler
// Purpose  : Command queue and issue sequencer between the debounced button
//            actions and the calculator stack datapath. Action pulses and
//            their payloads are buffered in a DEPTH-entry FIFO and replayed
//            to the calculator one at a time as single-cycle pulses. Issue is
//            held off while the calculator reports calc_busy, so actions
//            arriving during long operations are not lost.
//
// Ports    : clk                 system clock, all logic on posedge
//            reset               synchronous, active-high
//            push_num            action pulse: push number
//            shift_and_push      action pulse: shift and push
//            do_other_op         action pulse: other operation
//            input_number        payload sampled with the pulse
//            other_op_code       op code sampled with do_other_op
//            calc_busy           calculator executing a command
//            calc_push_num       issued pulse
//            calc_shift_and_push issued pulse
//            calc_do_other_op    issued pulse
//            calc_number         payload of the last issued command
//            calc_op_code        op code of the last issued command
//            queue_level         number of valid FIFO entries
//            idle                FSM in IDLE with an empty FIFO
//            dropped             sticky, a command was discarded
//            timeout             sticky, busy-timeout fired
//
// Options  : CALC_SCHED_BUSY_TIMEOUT_EN - when defined, WAIT is bounded to
//            256 busy cycles; on expiry the FSM returns to IDLE and the
//            sticky timeout flag is set. When undefined, timeout is tied 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module calc_cmd_scheduler #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_num,
    input  logic                     shift_and_push,
    input  logic                     do_other_op,
    input  logic [DATA_W-1:0]        input_number,
    input  logic [2:0]               other_op_code,
    input  logic                     calc_busy,
    output logic                     calc_push_num,
    output logic                     calc_shift_and_push,
    output logic                     calc_do_other_op,
    output logic [DATA_W-1:0]        calc_number,
    output logic [2:0]               calc_op_code,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     idle,
    output logic                     dropped,
    output logic                     timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LW = $clog2(DEPTH) + 1;
    localparam int c_EW = 2 + 3 + DATA_W;

    localparam logic [c_LW-1:0] c_FULL_LEVEL = c_LW'(DEPTH);

    localparam logic [1:0] c_KIND_PUSH  = 2'd0;
    localparam logic [1:0] c_KIND_SHIFT = 2'd1;
    localparam logic [1:0] c_KIND_OTHER = 2'd2;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;
    localparam logic [1:0] c_ST_WAIT   = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_LW-1:0]   r_level;
    logic              r_push;
    logic              r_shift;
    logic              r_other;
    logic [DATA_W-1:0] r_number;
    logic [2:0]        r_op_code;
    logic              r_dropped;

    // ------------------------------------------------------------------------
    // Enqueue arbitration: do_other_op > shift_and_push > push_num
    // ------------------------------------------------------------------------
    logic              w_req_any;
    logic              w_req_multi;
    logic [1:0]        w_req_kind;
    logic [2:0]        w_req_op;
    logic [c_EW-1:0]   w_wr_entry;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;

    always_comb begin
        w_req_any   = push_num | shift_and_push | do_other_op;
        w_req_multi = (push_num & shift_and_push) |
                      (push_num & do_other_op)    |
                      (shift_and_push & do_other_op);
        w_req_kind  = c_KIND_PUSH;
        w_req_op    = 3'd0;
        if (do_other_op) begin
            w_req_kind = c_KIND_OTHER;
            w_req_op   = other_op_code;
        end else if (shift_and_push) begin
            w_req_kind = c_KIND_SHIFT;
        end
    end

    assign w_wr_entry = {w_req_kind, w_req_op, input_number};

    // Full/empty come from the level at the start of the cycle, so a pop in
    // the same cycle never makes room for an incoming command.
    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);
    assign w_wr_en = w_req_any & ~w_full;
    assign w_rd_en = (r_state == c_ST_IDLE) & ~w_empty & ~calc_busy;

    // Head-of-queue decode
    logic [c_EW-1:0]   w_head;
    logic [1:0]        w_head_kind;
    logic [2:0]        w_head_op;
    logic [DATA_W-1:0] w_head_num;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_kind = w_head[c_EW-1 -: 2];
    assign w_head_op   = w_head[DATA_W +: 3];
    assign w_head_num  = w_head[DATA_W-1:0];

    // ------------------------------------------------------------------------
    // FIFO storage (no reset needed: pointers/level define validity)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // ------------------------------------------------------------------------
    // Optional busy timeout
    // ------------------------------------------------------------------------
    logic w_timeout_hit;

`ifdef CALC_SCHED_BUSY_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    // Counter is zeroed while in ISSUE (i.e. on entry to SETTLE) and counts
    // every WAIT cycle spent with calc_busy still high; the 256th such cycle
    // forces the FSM back to IDLE.
    assign w_timeout_hit = (r_state == c_ST_WAIT) & calc_busy & (r_wait_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == c_ST_ISSUE) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == c_ST_WAIT) && calc_busy) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Pointers, level, sticky drop flag and issue FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_push    <= 1'b0;
            r_shift   <= 1'b0;
            r_other   <= 1'b0;
            r_number  <= '0;
            r_op_code <= 3'd0;
            r_dropped <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + {{(c_LW-1){1'b0}}, w_wr_en}
                               - {{(c_LW-1){1'b0}}, w_rd_en};

            // Arbitration losers and commands hitting a full queue are lost
            if (w_req_multi || (w_req_any && w_full)) begin
                r_dropped <= 1'b1;
            end

            // Issue pulses default low; only the IDLE->ISSUE step raises one
            r_push  <= 1'b0;
            r_shift <= 1'b0;
            r_other <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_rd_en) begin
                        r_state   <= c_ST_ISSUE;
                        r_number  <= w_head_num;
                        r_op_code <= w_head_op;
                        case (w_head_kind)
                            c_KIND_PUSH:  r_push  <= 1'b1;
                            c_KIND_SHIFT: r_shift <= 1'b1;
                            c_KIND_OTHER: r_other <= 1'b1;
                            default:      r_push  <= 1'b0;
                        endcase
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    // calc_busy deliberately ignored: the calculator needs a
                    // cycle after the pulse to raise it.
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (!calc_busy || w_timeout_hit) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign calc_push_num       = r_push;
    assign calc_shift_and_push = r_shift;
    assign calc_do_other_op    = r_other;
    assign calc_number         = r_number;
    assign calc_op_code        = r_op_code;
    assign queue_level         = r_level;
    assign idle                = (r_state == c_ST_IDLE) & w_empty;
    assign dropped             = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_calc_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_cmd_scheduler
// Purpose  : Self-checking bench for calc_cmd_scheduler. A stimulus process
//            drives one cycle at a time and updates a behavioural model
//            (command queue plus issue-eligibility timing rules); expected
//            issues go into a scoreboard queue that an independent monitor
//            drains whenever the DUT raises an issue pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_cmd_scheduler;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

`ifdef CALC_SCHED_BUSY_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              push_num = 1'b0;
    logic              shift_and_push = 1'b0;
    logic              do_other_op = 1'b0;
    logic [DATA_W-1:0] input_number = '0;
    logic [2:0]        other_op_code = 3'd0;
    logic              calc_busy = 1'b0;
    logic              calc_push_num;
    logic              calc_shift_and_push;
    logic              calc_do_other_op;
    logic [DATA_W-1:0] calc_number;
    logic [2:0]        calc_op_code;
    logic [$clog2(DEPTH):0] queue_level;
    logic              idle;
    logic              dropped;
    logic              timeout;

    always #5 clk = ~clk;

    calc_cmd_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .push_num            (push_num),
        .shift_and_push      (shift_and_push),
        .do_other_op         (do_other_op),
        .input_number        (input_number),
        .other_op_code       (other_op_code),
        .calc_busy           (calc_busy),
        .calc_push_num       (calc_push_num),
        .calc_shift_and_push (calc_shift_and_push),
        .calc_do_other_op    (calc_do_other_op),
        .calc_number         (calc_number),
        .calc_op_code        (calc_op_code),
        .queue_level         (queue_level),
        .idle                (idle),
        .dropped             (dropped),
        .timeout             (timeout)
    );

    // ------------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------------
    typedef struct {
        int unsigned kind;   // 0 push, 1 shift, 2 other
        int unsigned op;
        int unsigned num;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int unsigned tag;    // clock edge after which the pulse is visible
    } iss_t;

    cmd_t fifo_q[$];
    iss_t iss_q[$];

    bit          m_elig;     // FSM able to pop in the current cycle
    int          m_last_pop;
    bit          m_dropped;
    bit          m_timeout;
    int unsigned m_num;
    int unsigned m_op;

    int          exp_level;
    bit          exp_idle;
    bit          exp_dropped;
    bit          exp_timeout;
    int unsigned exp_num;
    int unsigned exp_op;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input int unsigned got, input int unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edges, got, want);
        end
    endfunction

    // ------------------------------------------------------------------------
    // One clock cycle of stimulus plus the reference model update
    // ------------------------------------------------------------------------
    task automatic step(input bit rst, input bit pn, input bit sp, input bit oo,
                        input int unsigned num, input int unsigned op, input bit busy);
        int   c;
        int   start;
        cmd_t h;
        cmd_t w;
        @(negedge clk);
        reset          = rst;
        push_num       = pn;
        shift_and_push = sp;
        do_other_op    = oo;
        input_number   = num[DATA_W-1:0];
        other_op_code  = op[2:0];
        calc_busy      = busy;

        c = edges + 1;
        if (rst) begin
            fifo_q.delete();
            iss_q.delete();
            m_elig     = 1'b1;
            m_last_pop = -1000;
            m_dropped  = 1'b0;
            m_timeout  = 1'b0;
            m_num      = 0;
            m_op       = 0;
        end else begin
            start = fifo_q.size();
            // A pop needs an entry present at the start of the cycle
            if (m_elig && start > 0 && !busy) begin
                h = fifo_q.pop_front();
                iss_q.push_back('{h, c});
                m_num      = h.num;
                m_op       = h.op;
                m_elig     = 1'b0;
                m_last_pop = c;
            end
            if (pn || sp || oo) begin
                if (oo)      w = '{2, op & 7, num & 255};
                else if (sp) w = '{1, 0, num & 255};
                else         w = '{0, 0, num & 255};
                if ((int'(pn) + int'(sp) + int'(oo)) > 1) m_dropped = 1'b1;
                if (start < DEPTH) fifo_q.push_back(w);
                else               m_dropped = 1'b1;
            end
            // Waiting phase begins 3 cycles after a pop; the first cycle in it
            // with busy low (or the 256th busy cycle, when bounded) re-enables
            // popping from the next cycle on.
            if (!m_elig && c >= m_last_pop + 3) begin
                if (!busy) begin
                    m_elig = 1'b1;
                end else if (c_TO_EN && c == m_last_pop + 258) begin
                    m_elig    = 1'b1;
                    m_timeout = 1'b1;
                end
            end
        end
        exp_level   = fifo_q.size();
        exp_idle    = m_elig && (fifo_q.size() == 0);
        exp_dropped = m_dropped;
        exp_timeout = m_timeout;
        exp_num     = m_num;
        exp_op      = m_op;
        chk_en      = 1'b1;
    endtask

    task automatic quiet(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, busy);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: scoreboard drain and status checks after every edge
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        logic [2:0] got_p;
        logic [2:0] want_p;
        iss_t       e;
        edges = edges + 1;
        #1;
        if (chk_en) begin
            got_p = {calc_do_other_op, calc_shift_and_push, calc_push_num};
            if (got_p != 3'b000) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", got_p, 0);
                end else begin
                    e = iss_q.pop_front();
                    want_p = 3'b001 << e.c.kind;
                    check("issue_time", edges, e.tag);
                    check("issue_kind", got_p, want_p);
                    check("issue_num", calc_number, e.c.num);
                    check("issue_op", calc_op_code, e.c.op);
                end
            end else if (iss_q.size() > 0 && iss_q[0].tag <= edges) begin
                e = iss_q.pop_front();
                check("missing_issue", got_p, 3'b001 << e.c.kind);
            end
            check("queue_level", queue_level, exp_level);
            check("idle", idle, exp_idle);
            check("dropped", dropped, exp_dropped);
            check("timeout", timeout, exp_timeout);
            check("calc_number_hold", calc_number, exp_num);
            check("calc_op_hold", calc_op_code, exp_op);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        quiet(2, 0);

        // Single push, 0x2A
        step(0, 1, 0, 0, 'h2A, 0, 0);
        quiet(8, 0);

        // Busy hold-off: other op 3, busy for 10 cycles after ISSUE
        step(0, 0, 0, 1, 'h55, 3, 0);
        quiet(2, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 'h77, 0, 1);
        quiet(8, 1);
        quiet(10, 0);

        // Overflow: one in flight, five more while busy
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 'h01, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 6; i++) step(0, 1, 0, 0, i, 0, 1);
        quiet(5, 1);
        quiet(25, 0);

        // Collision: push_num and do_other_op together
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 'h33, 5, 0);
        quiet(8, 0);

        // Reset in WAIT with 3 entries queued
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 'h10, 0, 0);
        quiet(2, 0);
        step(0, 1, 0, 0, 'h11, 0, 1);
        step(0, 0, 1, 0, 'h12, 0, 1);
        step(0, 0, 0, 1, 'h13, 6, 1);
        quiet(2, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        quiet(3, 1);
        quiet(10, 0);

        // Long busy: timeout behaviour, one command queued meanwhile
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 'hA0, 0, 0);
        quiet(2, 0);
        quiet(100, 1);
        step(0, 0, 0, 1, 'hA1, 2, 1);
        quiet(199, 1);
        quiet(10, 0);

        // Randomised traffic
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 300) == 0,
                 ($urandom % 5) == 0,
                 ($urandom % 6) == 0,
                 ($urandom % 6) == 0,
                 $urandom % 256,
                 $urandom % 8,
                 ($urandom % 3) == 0);
        end
        quiet(20, 0);

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        if (iss_q.size() != 0) check("pending_issues", iss_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
